pipe_stage_skid: RTL and testbench

Parametrised, handshaked pipeline stage register replacing the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V pipeline. Carries an opaque data payload plus a control field through one stage with a valid/ready handshake. A 2-entry skid buffer decouples upstream ready from downstream ready, and the block supports global stall (memory busy-wait), flush with bubble insertion (branch/jump redirect) and a saturating stall-cycle counter. One instance per stage boundary, sitting between stage logic blocks.

---
 rtl/pipe_stage_skid.sv | 164 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: handshaked inter-stage register with a 2-entry skid buffer.
// Carries an opaque {DATA, CTRL} beat between two pipeline stages. The
// registered output side (main) plus one skid entry let IN_READY be a
// registered-state function, so upstream ready never depends on OUT_READY.
// Global STALL freezes the stage. FLUSH drops every held beat and turns the
// held control fields into bubbles. A saturating counter records stalled
// and back-pressured cycles for performance monitoring.
module pipe_stage_skid #(
  parameter int                 DATA_W      = 128,
  parameter int                 CTRL_W      = 24,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [1:0]        OCCUPANCY,
  output logic [CNT_W-1:0]  STALL_CNT
);

  // State encoding equals the number of held beats, so OCCUPANCY is the
  // state register itself.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q,     state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              out_valid_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic stall_event;

  // Upstream may push whenever a slot is free and the pipe is not frozen or
  // being redirected; this is the only combinational input-to-output path.
  assign in_ready    = (state_q != S_TWO) & ~STALL & ~FLUSH;
  assign in_fire     = IN_VALID & in_ready;
  assign out_fire    = out_valid_q & OUT_READY & ~STALL;
  assign stall_event = STALL | (out_valid_q & ~OUT_READY);

  // Next-state and datapath selection for the main/skid pair.
  always_comb begin
    // NOTE: every variable gets a hold default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (FLUSH) begin
      // Redirect: drop everything. Data payloads are left untouched because
      // a bubble is identified by its control field alone.
      state_d     = S_EMPTY;
      main_ctrl_d = BUBBLE_CTRL;
      skid_ctrl_d = BUBBLE_CTRL;
    end else if (!STALL) begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            // Pass-through: the new beat replaces the departing one.
            main_data_d = IN_DATA;
            main_ctrl_d = IN_CTRL;
          end else if (in_fire) begin
            // Downstream blocked: park the younger beat in skid.
            state_d     = S_TWO;
            skid_data_d = IN_DATA;
            skid_ctrl_d = IN_CTRL;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            // Skid is always younger than main, so it moves forward.
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Stage storage and registered output flags; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      // NOTE: the payload registers are reset too, because OUT_DATA must read
      // zero after reset; nothing here is a RAM, so the cost is only a mux.
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= BUBBLE_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= BUBBLE_CTRL;
      out_valid_q <= 1'b0;
      out_ctrl_q  <= BUBBLE_CTRL;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      // Valid and the masked control are precomputed from the next state so
      // both leave the block straight from a flop.
      out_valid_q <= (state_d != S_EMPTY);
      out_ctrl_q  <= (state_d == S_EMPTY) ? BUBBLE_CTRL : main_ctrl_d;
    end
  end

  // Saturating count of cycles the stage is frozen or back-pressured.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_cnt_q <= '0;
    end else if (stall_event && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign IN_READY  = in_ready;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = main_data_q;
  assign OUT_CTRL  = out_ctrl_q;
  assign OCCUPANCY = state_q;
  assign STALL_CNT = stall_cnt_q;

  // Structural invariants of the stage.
  a_state_legal : assert property (@(posedge CLK) disable iff (!RESET)
    state_q != 2'd3);
  a_valid_match : assert property (@(posedge CLK) disable iff (!RESET)
    out_valid_q == (state_q != S_EMPTY));
  a_bubble_ctrl : assert property (@(posedge CLK) disable iff (!RESET)
    !out_valid_q |-> (out_ctrl_q == BUBBLE_CTRL));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue scoreboard tracks every
// accepted beat and the expected stall count, and directed phases cover
// reset, streaming, backpressure, stall, flush and counter saturation.
module tb_pipe_stage_skid;

  localparam int             DW  = 128;
  localparam int             CW  = 24;
  localparam logic [CW-1:0]  BUB = 24'h000F00;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [DW-1:0] sat_out_data;
  logic [CW-1:0] sat_out_ctrl;
  logic [1:0]    sat_occupancy;
  logic [3:0]    sat_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(16)) u_dut (
    .CLK(clk), .RESET(reset), .STALL(stall), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data), .OUT_CTRL(out_ctrl),
    .OCCUPANCY(occupancy), .STALL_CNT(stall_cnt)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(4)) u_sat (
    .CLK(clk), .RESET(reset), .STALL(stall), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(sat_in_ready), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
    .OUT_VALID(sat_out_valid), .OUT_READY(out_ready), .OUT_DATA(sat_out_data),
    .OUT_CTRL(sat_out_ctrl), .OCCUPANCY(sat_occupancy), .STALL_CNT(sat_stall_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    int            cyc;
  } beat_t;

  beat_t  sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  bit     armed    = 1'b0;
  bit     lat_chk  = 1'b0;
  longint exp_cnt  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int k);
    return {32'hC0DE_0000 + 32'(k), 64'(k) * 64'h0101_0101_0101_0101, 32'(k)};
  endfunction

  // Bit 23 set keeps every real beat distinct from the bubble code.
  function automatic logic [CW-1:0] mk_ctrl(input int k);
    return 24'h800000 | 24'(k & 16'hFFFF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k);
    in_valid = 1'b1;
    in_data  = mk_data(k);
    in_ctrl  = mk_ctrl(k);
  endtask

  // Hold a beat until the stage accepts it, with a bounded wait.
  task automatic send_wait(input int k);
    bit done;
    done = 1'b0;
    drive(k);
    #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  // Scoreboard and cycle model, sampled mid-cycle away from the rising edge.
  always @(negedge clk) begin
    bit    exp_ready;
    beat_t e;
    cyc++;
    exp_ready = (sb.size() < 2) && !stall && !flush;
    if (armed) begin
      check("out_valid", out_valid, sb.size() != 0);
      check("occupancy", occupancy, sb.size());
      check("in_ready", in_ready, exp_ready);
      check("stall_cnt", stall_cnt, exp_cnt);
      check("sat_cnt", sat_stall_cnt, (exp_cnt > 15) ? 15 : exp_cnt);
      if (sb.size() == 0) check("bubble_ctrl", out_ctrl, BUB);
    end
    if (!reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if ((stall || (sb.size() != 0 && !out_ready)) && exp_cnt < 65535) exp_cnt++;
      if (flush) begin
        sb.delete();
      end else begin
        if (sb.size() != 0 && out_ready && !stall) begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_ctrl", out_ctrl, e.ctrl);
          if (lat_chk) check("latency", cyc - e.cyc, 1);
        end
        if (in_valid && exp_ready) sb.push_back('{in_data, in_ctrl, cyc});
      end
    end
  end

  initial begin
    int c0;

    // Reset held two cycles with a beat offered.
    drive(99);
    out_ready = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ctrl", out_ctrl, BUB);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    tick();

    // Streaming: 1..8 back-to-back, one-cycle latency, never more than one held.
    lat_chk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(k);
      tick();
      check("stream_occ_le1", occupancy <= 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    lat_chk = 1'b0;

    // Backpressure: A held, B in skid, C refused until a slot frees.
    drive(20);
    tick();
    c0 = int'(stall_cnt);
    out_ready = 1'b0;
    drive(21);
    tick();
    drive(22);
    #1;
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_occupancy", occupancy, 2'd2);
    check("bp_head", out_data, mk_data(20));
    tick();
    tick();
    check("bp_head_held", out_data, mk_data(20));
    check("bp_blocked_cnt", int'(stall_cnt) - c0, 3);
    out_ready = 1'b1;
    tick();
    check("bp_ready_rise", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();

    // Stall five cycles while full with downstream ready.
    drive(30);
    tick();
    out_ready = 1'b0;
    drive(31);
    tick();
    out_ready = 1'b1;
    stall     = 1'b1;
    drive(32);
    c0 = int'(stall_cnt);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_head", out_data, mk_data(30));
      check("stall_occ", occupancy, 2'd2);
      check("stall_in_ready", in_ready, 1'b0);
    end
    check("stall_cnt_delta", int'(stall_cnt) - c0, 5);
    stall = 1'b0;
    send_wait(32);
    for (int i = 0; i < 3; i++) tick();

    // Flush from full with a concurrent beat, without and then with stall.
    for (int rep = 0; rep < 2; rep++) begin
      out_ready = 1'b0;
      drive(40 + rep * 10);
      tick();
      drive(41 + rep * 10);
      tick();
      drive(42 + rep * 10);
      flush = 1'b1;
      stall = (rep == 1);
      tick();
      flush    = 1'b0;
      stall    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", out_valid, 1'b0);
      check("flush_ctrl", out_ctrl, BUB);
      check("flush_occ", occupancy, 2'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("flush_no_beat", out_valid, 1'b0);
    end

    // Reset pulse with a held beat loses it and clears the counter.
    out_ready = 1'b0;
    drive(60);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rpulse_valid", out_valid, 1'b0);
    check("rpulse_data", out_data, '0);
    check("rpulse_cnt", stall_cnt, 16'd0);
    check("rpulse_sat_cnt", sat_stall_cnt, 4'd0);

    // Saturation: 20 stalled cycles on a 4-bit counter.
    out_ready = 1'b1;
    stall     = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_value", sat_stall_cnt, 4'd15);
    check("sat_wide_cnt", stall_cnt, 16'd20);
    stall = 1'b0;
    tick();
    tick();

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
